// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Purpose  : Shared helpers for the Hamming SECDED pipeline: parity-width
//            derivation, power-of-two test, data-index to Hamming-position
//            mapping and the word classification enum.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2
  } class_e;

  // Smallest r with 2^r >= data_w + r + 1. r is monotonic, so a fixed number
  // of conditional increments is enough for data_w up to 57 (r <= 7).
  function automatic int par_w_f(input int data_w);
    int r;
    r = 1;
    for (int k = 0; k < 8; k++) begin
      if ((1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Hamming position (1-based) of data bit idx: the idx-th position that is
  // not a power of two, counting from position 3.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
// Module   : hamming_syndrome
// Purpose  : Combinational syndrome and overall-parity computation.
// Ports    : code_i     - received codeword (bit i = position i+1, MSB = overall
//                         parity bit)
//            syndrome_o - XOR of positions of all set bits below the MSB
//            parity_o   - XOR of every codeword bit
// Revision : 1.0 - initial release
// ============================================================================
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [PAR_W-1:0]  syndrome_o,
  output logic              parity_o
);

  always_comb begin
    syndrome_o = '0;
    for (int i = 0; i < CODE_W - 1; i++) begin
      if (code_i[i]) syndrome_o = syndrome_o ^ PAR_W'(i + 1);
    end
    parity_o = ^code_i;
  end

endmodule
`default_nettype wire

// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_pipe
// Purpose  : Two-stage valid/ready SECDED decoder with saturating single- and
//            double-error counters.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready/in_code             - codeword input handshake
//            out_valid/out_ready                   - result handshake
//            out_data/out_syndrome/out_single/out_double - decoded result
//            cnt_clear                             - synchronous counter clear
//            cnt_single/cnt_double                 - saturating error counters
// Revision : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = par_w_f(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_single,
  output logic              out_double,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  // ---------------- stage 1: code, syndrome, parity -------------------------
  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_par_q;
  logic [PAR_W-1:0]  syn_d;
  logic              par_d;

  // ---------------- stage 2: decoded result ---------------------------------
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [PAR_W-1:0]  out_syn_q;
  logic              out_single_q, out_double_q;
  class_e            cls_d;
  logic [CODE_W-1:0] fixed_code_d;

  logic [CNT_W-1:0]  cnt_single_q, cnt_double_q;

  logic s2_load;
  logic s1_load;
  logic out_fire;

  // Stage 2 moves whenever its slot is free or being drained; stage 1 moves
  // when empty or when it can hand its word on, which collapses bubbles.
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_fire = out_valid_q && out_ready;

  hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code_i     (in_code),
    .syndrome_o (syn_d),
    .parity_o   (par_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= syn_d;
        s1_par_q  <= par_d;
      end
    end
  end

  // Classification and correction. A nonzero syndrome that points past the
  // last codeword position cannot be a single flip, so it is uncorrectable.
  always_comb begin
    fixed_code_d = s1_code_q;
    cls_d        = CLEAN;
    if (s1_par_q) begin
      if (s1_syn_q == '0) begin
        cls_d = SINGLE;
      end else if (int'(s1_syn_q) <= CODE_W - 1) begin
        cls_d = SINGLE;
        for (int i = 0; i < CODE_W - 1; i++) begin
          if (s1_syn_q == PAR_W'(i + 1)) fixed_code_d[i] = ~s1_code_q[i];
        end
      end else begin
        cls_d = DOUBLE;
      end
    end else if (s1_syn_q != '0) begin
      cls_d = DOUBLE;
    end
    out_data_d = '0;
    for (int j = 0; j < DATA_W; j++) begin
      out_data_d[j] = fixed_code_d[data_pos(j) - 1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= out_data_d;
        out_syn_q    <= s1_syn_q;
        out_single_q <= (cls_d == SINGLE);
        out_double_q <= (cls_d == DOUBLE);
      end
    end
  end

  // Counters advance on output handshakes only; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (cnt_clear) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (out_fire) begin
      if (out_single_q && cnt_single_q != '1) cnt_single_q <= cnt_single_q + 1'b1;
      if (out_double_q && cnt_double_q != '1) cnt_double_q <= cnt_double_q + 1'b1;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syn_q;
  assign out_single   = out_single_q;
  assign out_double   = out_double_q;
  assign cnt_single   = cnt_single_q;
  assign cnt_double   = cnt_double_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_secded_pipe
// Purpose  : Scoreboard bench for hamming_secded_pipe (DATA_W=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_pipe;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int PAR_W  = 3;
  localparam int CODE_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [PAR_W-1:0]  s;
    logic              sg;
    logic              db;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CODE_W-1:0] in_code = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_single;
  logic              out_double;
  logic              cnt_clear = 1'b0;
  logic [CNT_W-1:0]  cnt_single;
  logic [CNT_W-1:0]  cnt_double;

  int total = 0;
  int bad   = 0;
  bit rand_mode = 0;

  exp_t q[$];
  int   m_single = 0;
  int   m_double = 0;
  int   occ = 0;
  bit   stall = 0;
  logic [10:0] held;

  hamming_secded_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_single   (out_single),
    .out_double   (out_double),
    .cnt_clear    (cnt_clear),
    .cnt_single   (cnt_single),
    .cnt_double   (cnt_double)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decoder straight from the code rules.
  function automatic exp_t ref_decode(input logic [CODE_W-1:0] c);
    exp_t e;
    int   s;
    int   k;
    bit   p;
    logic [CODE_W-1:0] w;
    s = 0;
    for (int i = 0; i < CODE_W - 1; i++) if (c[i]) s = s ^ (i + 1);
    p = ^c;
    w = c;
    e.sg = 0;
    e.db = 0;
    if (p && s == 0) e.sg = 1;
    else if (p && s <= CODE_W - 1) begin e.sg = 1; w[s-1] = ~w[s-1]; end
    else if (s != 0) e.db = 1;
    k = 0;
    e.d = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin e.d[k] = w[pos-1]; k++; end
    end
    e.s = PAR_W'(s);
    return e;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int k;
    int s;
    c = '0;
    k = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin c[pos-1] = d[k]; k++; end
    end
    s = 0;
    for (int i = 0; i < CODE_W - 1; i++) if (c[i]) s = s ^ (i + 1);
    for (int b = 0; b < PAR_W; b++) c[(1 << b) - 1] = s[b];
    c[CODE_W-1] = ^c[CODE_W-2:0];
    return c;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   fire;
    bit   flag_s;
    bit   flag_d;
    if (!rst_n) begin
      q.delete();
      m_single = 0;
      m_double = 0;
      occ      = 0;
      stall    = 0;
    end else begin
      chk("cnt_single", 32'(cnt_single), 32'(m_single));
      chk("cnt_double", 32'(cnt_double), 32'(m_double));
      chk("in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
      if (out_single && out_double) chk("flags_exclusive", 32'(2'b11), 32'(2'b00));
      if (stall)
        chk("hold_stable", 32'({out_valid, out_data, out_syndrome, out_single, out_double}),
            32'(held));
      stall = out_valid && !out_ready;
      held  = {out_valid, out_data, out_syndrome, out_single, out_double};
      fire   = out_valid && out_ready;
      flag_s = 0;
      flag_d = 0;
      if (fire) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_syndrome", 32'(out_syndrome), 32'(e.s));
          chk("out_single", 32'(out_single), 32'(e.sg));
          chk("out_double", 32'(out_double), 32'(e.db));
          flag_s = e.sg;
          flag_d = e.db;
        end
        occ--;
      end
      if (cnt_clear) begin
        m_single = 0;
        m_double = 0;
      end else begin
        if (flag_s && m_single < (1 << CNT_W) - 1) m_single++;
        if (flag_d && m_double < (1 << CNT_W) - 1) m_double++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_decode(in_code));
        occ++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom % 2);
    end
  end

  task automatic push_word(input logic [CODE_W-1:0] code);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_code  = code;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  // Pipeline must be empty and out_ready high on entry.
  task automatic directed(input string name, input logic [CODE_W-1:0] code,
                          input logic [DATA_W-1:0] ed, input logic [PAR_W-1:0] es,
                          input logic esg, input logic edb);
    push_word(code);
    @(negedge clk);
    chk({name, "_lat_early"}, 32'(out_valid), 32'(0));
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'(1));
    chk({name, "_data"}, 32'(out_data), 32'(ed));
    chk({name, "_syn"}, 32'(out_syndrome), 32'(es));
    chk({name, "_single"}, 32'(out_single), 32'(esg));
    chk({name, "_double"}, 32'(out_double), 32'(edb));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rand_mode = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && occ == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CODE_W-1:0] c;
    int nerr;
    int b0;
    int b1;
    bit seen;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_cnt", 32'({cnt_single, cnt_double}), 32'(0));
    chk("rst_out_data", 32'({out_data, out_syndrome, out_single, out_double}), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    directed("clean55", 8'h55, 4'b1011, 3'b000, 1'b0, 1'b0);
    directed("single45", 8'h45, 4'b1011, 3'b101, 1'b1, 1'b0);
    chk("cnt_single_after45", 32'(cnt_single), 32'(1));
    directed("ovrD5", 8'hD5, 4'b1011, 3'b000, 1'b1, 1'b0);
    directed("double56", 8'h56, 4'b1011, 3'b011, 1'b0, 1'b1);
    chk("cnt_double_after56", 32'(cnt_double), 32'(1));

    // Random stream with random backpressure.
    rand_mode = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 4 == 0) begin
        c = CODE_W'($urandom);
      end else begin
        c    = encode(DATA_W'($urandom));
        nerr = int'($urandom % 3);
        b0   = int'($urandom % CODE_W);
        b1   = (b0 + 1 + int'($urandom % (CODE_W - 1))) % CODE_W;
        if (nerr >= 1) c[b0] = ~c[b0];
        if (nerr == 2) c[b1] = ~c[b1];
      end
      push_word(c);
      if ($urandom % 3 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    push_word(8'h45);
    push_word(8'h56);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_cnt", 32'({cnt_single, cnt_double}), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_no_output", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    directed("postrst56", 8'h56, 4'b1011, 3'b011, 1'b0, 1'b1);
    chk("postrst_cnt", 32'({cnt_single, cnt_double}), 32'({2'd0, 2'd1}));

    // Saturation with a 2-bit counter.
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    for (int n = 0; n < 5; n++) push_word(8'h45);
    drain();
    chk("cnt_single_sat", 32'(cnt_single), 32'(3));

    // Clear coinciding with a flagged output handshake.
    out_ready = 1'b0;
    push_word(8'h45);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) chk("clr_wait_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    chk("clear_wins", 32'(cnt_single), 32'(0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
